// File: rtl/turfio_bus_master.sv
// turfio_bus_master: TURFIO-side initiator for the byte-serial TURF bus.
// Sends address then four data bytes LSB first; reads are reassembled.
module turfio_bus_master #(
  parameter int RESET_IDLE = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wr_i,
  input  logic [7:0]  cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        nCSTURF,
  output logic        TURF_WnR,
  inout  wire  [7:0]  TURF_DIO
);

  typedef enum logic [3:0] {
    HOLD, IDLE,
    W_ADDR, W_B0, W_B1, W_B2, W_B3,
    R_ADDR, R_B0, R_B1, R_B2, R_B3, R_DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  hold_cnt, hold_cnt_n;
  logic [31:0] wd_q, wd_n;
  logic [23:0] sh_q, sh_n;
  logic        ncs_n, wnr_n, oe_n, rv_n;
  logic [7:0]  dout_n;
  logic [31:0] rdata_n;
  logic        dio_oe;
  logic [7:0]  dio_out;
  logic [7:0]  din_q;

  assign TURF_DIO    = dio_oe ? dio_out : 8'hzz;
  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE) && (state != HOLD);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= HOLD;
      hold_cnt    <= 8'd0;
      wd_q        <= 32'd0;
      sh_q        <= 24'd0;
      nCSTURF     <= 1'b1;
      TURF_WnR    <= 1'b1;
      dio_oe      <= 1'b0;
      dio_out     <= 8'd0;
      din_q       <= 8'd0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'd0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_cnt_n;
      wd_q        <= wd_n;
      sh_q        <= sh_n;
      nCSTURF     <= ncs_n;
      TURF_WnR    <= wnr_n;
      dio_oe      <= oe_n;
      dio_out     <= dout_n;
      din_q       <= TURF_DIO;
      rsp_valid_o <= rv_n;
      rsp_rdata_o <= rdata_n;
    end
  end

  // Next pad levels are computed here and registered in the IOBs.
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    wd_n       = wd_q;
    sh_n       = sh_q;
    ncs_n      = 1'b1;
    wnr_n      = 1'b1;
    oe_n       = 1'b0;
    dout_n     = dio_out;
    rv_n       = 1'b0;
    rdata_n    = rsp_rdata_o;
    unique case (state)
      HOLD: begin
        hold_cnt_n = hold_cnt + 8'd1;
        if (hold_cnt == 8'(RESET_IDLE - 1))
          state_n = IDLE;
      end
      IDLE: begin
        if (cmd_valid_i) begin
          wd_n    = cmd_wdata_i;
          ncs_n   = 1'b0;
          wnr_n   = cmd_wr_i;
          dout_n  = cmd_addr_i;
          oe_n    = 1'b1;
          state_n = cmd_wr_i ? W_ADDR : R_ADDR;
        end
      end
      W_ADDR, W_B0, W_B1, W_B2: begin
        dout_n = wd_q[7:0];
        wd_n   = {8'd0, wd_q[31:8]};
        oe_n   = 1'b1;
        unique case (state)
          W_ADDR:  state_n = W_B0;
          W_B0:    state_n = W_B1;
          W_B1:    state_n = W_B2;
          default: state_n = W_B3;
        endcase
      end
      W_B3: state_n = IDLE;
      R_ADDR: begin
        wnr_n   = 1'b0;
        state_n = R_B0;
      end
      R_B0: begin
        wnr_n   = 1'b0;
        state_n = R_B1;
      end
      R_B1, R_B2: begin
        wnr_n   = 1'b0;
        sh_n    = {din_q, sh_q[23:8]};
        state_n = (state == R_B1) ? R_B2 : R_B3;
      end
      // WnR returns high one cycle early so the responder releases DIO.
      R_B3: begin
        sh_n    = {din_q, sh_q[23:8]};
        state_n = R_DONE;
      end
      R_DONE: begin
        rdata_n = {din_q, sh_q};
        rv_n    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = HOLD;
    endcase
  end

endmodule

// File: tb/tb_turfio_bus_master.sv
// tb_turfio_bus_master: directed vectors against a TURF responder model.
// Checks pad timing, read data, reset abort, idle and bus contention.
`timescale 1ns/1ps
module tb_turfio_bus_master;

  localparam logic [31:0] TURF_ID = 32'h5455_5246;
  localparam logic [31:0] NEXT_ID = 32'h0000_0C5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, busy;
  logic [31:0] rsp_rdata;
  logic        nCSTURF, TURF_WnR;
  wire  [7:0]  TURF_DIO;

  always #5 clk = ~clk;

  turfio_bus_master #(.RESET_IDLE(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_wr_i    (cmd_wr),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .busy_o      (busy),
    .nCSTURF     (nCSTURF),
    .TURF_WnR    (TURF_WnR),
    .TURF_DIO    (TURF_DIO)
  );

  // Responder model: drives read bytes from mid-T1, releases on WnR high.
  logic        m_oe = 1'b0;
  logic [7:0]  m_dout = 8'd0;
  logic [1:0]  m_st = 2'd0;
  logic [2:0]  m_ph = 3'd0;
  logic [5:0]  m_a = 6'd0;
  logic [31:0] m_sh = 32'd0;
  logic [31:0] m_rw = 32'd0;
  logic [31:0] m_regs [64];

  assign TURF_DIO = m_oe ? m_dout : 8'hzz;

  function automatic logic [31:0] m_rd(input logic [5:0] a);
    if (a == 6'd0) return TURF_ID;
    if (a == 6'd11) return NEXT_ID;
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    case (m_st)
      2'd0: if (!nCSTURF) begin
        m_a  <= TURF_DIO[5:0];
        m_ph <= 3'd0;
        m_rw <= m_rd(TURF_DIO[5:0]);
        m_st <= TURF_WnR ? 2'd1 : 2'd2;
      end
      2'd1: begin
        m_sh[{m_ph[1:0], 3'b000} +: 8] <= TURF_DIO;
        m_ph <= m_ph + 3'd1;
        if (m_ph == 3'd3) begin
          m_regs[m_a] <= {TURF_DIO, m_sh[23:0]};
          m_st <= 2'd0;
        end
      end
      2'd2: if (TURF_WnR) begin
        m_oe <= 1'b0;
        m_st <= 2'd0;
      end else if (m_ph != 3'd4) begin
        m_oe   <= 1'b1;
        m_dout <= m_rw[{m_ph[1:0], 3'b000} +: 8];
        m_ph   <= m_ph + 3'd1;
      end
      default: m_st <= 2'd0;
    endcase
  end

  // Bus monitor
  int          cyc = 0;
  int          n_ncs = 0;
  int          cont_a = 0;
  int          cont_b = 0;
  int          t0_q[$];
  logic [31:0] rsp_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!nCSTURF) begin
      n_ncs <= n_ncs + 1;
      t0_q.push_back(cyc);
    end
    if (rsp_valid) rsp_q.push_back(rsp_rdata);
    if (m_oe && dut.dio_oe) cont_a <= cont_a + 1;
  end

  always @(posedge clk) begin
    #1;
    if (m_oe && dut.dio_oe) cont_b <= cont_b + 1;
  end

  int n_chk = 0;
  int n_fail = 0;
  int n_iss = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [7:0] a,
                       input logic [31:0] d, input logic hold);
    int w = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    n_iss++;
    cmd_wr    = ~wr;
    cmd_addr  = ~a;
    cmd_wdata = ~d;
    cmd_valid = hold;
  endtask

  task automatic hold_check(input string nm);
    int lo = 0;
    @(negedge clk);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    while (!cmd_ready && lo < 30) begin
      lo++;
      @(negedge clk);
    end
    chk(nm, 32'(lo), 32'd8);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[7];

  task automatic run_vec(input vec_t v);
    logic [6:0]  s_ncs, s_wnr, s_oe, s_rdy, s_rv;
    logic [7:0]  s_dio [7];
    logic [31:0] rd;
    rd = 32'd0;
    issue(v.wr, v.addr, v.wdata, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      s_ncs[k] = nCSTURF;
      s_wnr[k] = TURF_WnR;
      s_oe[k]  = dut.dio_oe;
      s_rdy[k] = cmd_ready;
      s_rv[k]  = rsp_valid;
      s_dio[k] = TURF_DIO;
      if (k == 6) rd = rsp_rdata;
    end
    chk("ncs_seq", 32'(s_ncs), 32'h7E);
    chk("dio_addr", 32'(s_dio[0]), 32'(v.addr));
    if (v.wr) begin
      chk("wr_wnr", 32'(s_wnr), 32'h7F);
      chk("wr_oe", 32'(s_oe), 32'h1F);
      chk("wr_rdy", 32'(s_rdy), 32'h60);
      chk("wr_rv", 32'(s_rv), 32'h00);
      chk("wr_bytes", {s_dio[4], s_dio[3], s_dio[2], s_dio[1]}, v.wdata);
      chk("wr_model", m_regs[v.addr[5:0]], v.wdata);
    end else begin
      chk("rd_wnr", 32'(s_wnr), 32'h60);
      chk("rd_oe", 32'(s_oe), 32'h01);
      chk("rd_rdy", 32'(s_rdy), 32'h40);
      chk("rd_rv", 32'(s_rv), 32'h40);
      chk("rd_data", rd, v.exp);
    end
  endtask

  initial begin
    int b0, r0, lo;
    logic [31:0] last;
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = 8'd0;
    cmd_wdata = 32'd0;
    vt[0] = '{1'b1, 8'h06, 32'hDEAD_BEEF, 32'h0};
    vt[1] = '{1'b0, 8'h00, 32'h0, TURF_ID};
    vt[2] = '{1'b1, 8'h3F, 32'hA5A5_0F0F, 32'h0};
    vt[3] = '{1'b0, 8'h3F, 32'h0, 32'hA5A5_0F0F};
    vt[4] = '{1'b0, 8'h06, 32'h0, 32'hDEAD_BEEF};
    vt[5] = '{1'b1, 8'hC1, 32'h0000_0001, 32'h0};
    vt[6] = '{1'b0, 8'hC1, 32'h0, 32'h0000_0001};

    #1 rst_n = 1'b0;
    #20;
    chk("rst_ncs", 32'(nCSTURF), 32'd1);
    chk("rst_wnr", 32'(TURF_WnR), 32'd1);
    chk("rst_oe", 32'(dut.dio_oe), 32'd0);
    chk("rst_rdy", 32'(cmd_ready), 32'd0);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold_check("hold_init");

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Back-to-back stream with cmd_valid held high
    @(negedge clk);
    #1;
    b0 = t0_q.size();
    r0 = rsp_q.size();
    issue(1'b1, 8'h04, 32'h1234_5678, 1'b1);
    issue(1'b0, 8'h04, 32'h0, 1'b1);
    issue(1'b0, 8'h0B, 32'h0, 1'b0);
    repeat (12) @(negedge clk);
    #1;
    chk("str_t0_cnt", 32'(t0_q.size() - b0), 32'd3);
    chk("str_rsp_cnt", 32'(rsp_q.size() - r0), 32'd2);
    if (t0_q.size() >= b0 + 3) begin
      chk("str_gap_wr", 32'(t0_q[b0 + 1] - t0_q[b0]), 32'd6);
      chk("str_gap_rd", 32'(t0_q[b0 + 2] - t0_q[b0 + 1]), 32'd7);
    end
    if (rsp_q.size() >= r0 + 2) begin
      chk("str_rd0", rsp_q[r0], 32'h1234_5678);
      chk("str_rd1", rsp_q[r0 + 1], NEXT_ID);
    end

    // Reset during T3 of a read
    r0 = rsp_q.size();
    issue(1'b0, 8'h00, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_wnr", 32'(TURF_WnR), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ncs", 32'(nCSTURF), 32'd1);
    chk("abort_wnr", 32'(TURF_WnR), 32'd1);
    chk("abort_oe", 32'(dut.dio_oe), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdata", rsp_rdata, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold_check("hold_abort");
    #1;
    chk("abort_no_rsp", 32'(rsp_q.size() - r0), 32'd0);
    run_vec(vt[1]);

    // Idle: nothing moves without cmd_valid
    @(negedge clk);
    #1;
    b0   = t0_q.size();
    r0   = rsp_q.size();
    last = rsp_rdata;
    lo   = 0;
    repeat (30) begin
      @(negedge clk);
      if (!nCSTURF || !TURF_WnR) lo++;
    end
    #1;
    chk("idle_pads", 32'(lo), 32'd0);
    chk("idle_t0", 32'(t0_q.size() - b0), 32'd0);
    chk("idle_rsp", 32'(rsp_q.size() - r0), 32'd0);
    chk("idle_rdata", rsp_rdata, last);
    chk("idle_last", last, TURF_ID);

    chk("contention", 32'(cont_a + cont_b), 32'd0);
    chk("ncs_per_txn", 32'(n_ncs), 32'(n_iss));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
